// File: rtl/nibble_serializer_if.sv
// Handshake bundle for nibble_serializer: upstream 32-bit word channel,
// downstream 4-bit nibble channel and a busy flag.
// slave  : the serializer itself.
// master : the environment that offers words and accepts nibbles.
interface nibble_serializer_if;
    // upstream word channel
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic        msb_first;
    // downstream nibble channel
    logic        nib_valid;
    logic        nib_ready;
    logic [3:0]  nib_data;
    logic [2:0]  nib_idx;
    logic        nib_last;
    // status
    logic        busy;

    modport slave (
        input  word_valid, word_data, msb_first, nib_ready,
        output word_ready, nib_valid, nib_data, nib_idx, nib_last, busy
    );

    modport master (
        output word_valid, word_data, msb_first, nib_ready,
        input  word_ready, nib_valid, nib_data, nib_idx, nib_last, busy
    );
endinterface

// File: rtl/nibble_serializer.sv
// nibble_serializer: accepts a 32-bit word and emits it as eight 4-bit
// nibbles, LSB-first or MSB-first as selected with the word. The nibble
// order and data are latched at the word transfer, so later changes on
// word_data/msb_first never disturb the word in flight.
//
// Build option NIBBLE_SER_PRELOAD_EN: adds a one-word preload register so
// the next word can be accepted while the current one shifts out and then
// starts with no bubble (8 cycles per word instead of 9).
module nibble_serializer (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serializer_if.slave    bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Active word registers
    state_t      state_q, state_d;
    logic [31:0] word_q,  word_d;
    logic        msb_q,   msb_d;
    logic [2:0]  idx_q,   idx_d;

    // Handshake decode
    logic        word_rdy;
    logic        word_xfer;
    logic        nib_xfer;
    logic        at_last;

`ifdef NIBBLE_SER_PRELOAD_EN
    // Preload (held) word
    logic        pre_vld_q,  pre_vld_d;
    logic [31:0] pre_word_q, pre_word_d;
    logic        pre_msb_q,  pre_msb_d;

    // Ready whenever there is room to hold one more word
    assign word_rdy = !pre_vld_q;
`else
    // Without a preload slot, a word can only be taken when nothing shifts
    assign word_rdy = (state_q == IDLE);
`endif

    // Last nibble of the word is index 0 going down, index 7 going up
    assign at_last   = msb_q ? (idx_q == 3'd0) : (idx_q == 3'd7);
    assign word_xfer = bus.word_valid && word_rdy;
    assign nib_xfer  = (state_q == SHIFT) && bus.nib_ready;

    // Drive outputs; nibble fields are forced to zero outside SHIFT
    always_comb begin
        bus.word_ready = word_rdy;
        bus.nib_valid  = (state_q == SHIFT);
        bus.busy       = (state_q == SHIFT);
        bus.nib_data   = 4'd0;
        bus.nib_idx    = 3'd0;
        bus.nib_last   = 1'b0;
        if (state_q == SHIFT) begin
            bus.nib_data = word_q[{idx_q, 2'b00} +: 4];
            bus.nib_idx  = idx_q;
            bus.nib_last = at_last;
        end
    end

    // Next-state: load words, step the nibble index, chain into held word
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        msb_d   = msb_q;
        idx_d   = idx_q;
`ifdef NIBBLE_SER_PRELOAD_EN
        pre_vld_d  = pre_vld_q;
        pre_word_d = pre_word_q;
        pre_msb_d  = pre_msb_q;
`endif
        case (state_q)
            IDLE: begin
                if (word_xfer) begin
                    state_d = SHIFT;
                    word_d  = bus.word_data;
                    msb_d   = bus.msb_first;
                    idx_d   = bus.msb_first ? 3'd7 : 3'd0;
                end
            end
            SHIFT: begin
                if (nib_xfer && at_last) begin
`ifdef NIBBLE_SER_PRELOAD_EN
                    if (pre_vld_q) begin
                        // Held word becomes active with no idle cycle
                        pre_vld_d = 1'b0;
                        word_d    = pre_word_q;
                        msb_d     = pre_msb_q;
                        idx_d     = pre_msb_q ? 3'd7 : 3'd0;
                    end else if (word_xfer) begin
                        // Word arriving on the last-nibble edge goes straight in
                        word_d = bus.word_data;
                        msb_d  = bus.msb_first;
                        idx_d  = bus.msb_first ? 3'd7 : 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else begin
                    if (nib_xfer) begin
                        idx_d = msb_q ? (idx_q - 3'd1) : (idx_q + 3'd1);
                    end
`ifdef NIBBLE_SER_PRELOAD_EN
                    // Word accepted mid-shift parks in the preload slot
                    if (word_xfer) begin
                        pre_vld_d  = 1'b1;
                        pre_word_d = bus.word_data;
                        pre_msb_d  = bus.msb_first;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any active and held word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= 32'd0;
            msb_q   <= 1'b0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            msb_q   <= msb_d;
            idx_q   <= idx_d;
        end
    end

`ifdef NIBBLE_SER_PRELOAD_EN
    // Preload registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_vld_q  <= 1'b0;
            pre_word_q <= 32'd0;
            pre_msb_q  <= 1'b0;
        end else begin
            pre_vld_q  <= pre_vld_d;
            pre_word_q <= pre_word_d;
            pre_msb_q  <= pre_msb_d;
        end
    end
`endif

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer. Inputs are driven and outputs
// sampled 1 time unit after each rising edge. Expected nibble sequences
// are packed with the k-th emitted nibble in bits [4k+3:4k].
module tb_nibble_serializer;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    nibble_serializer_if bus();

    nibble_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".word_ready"}, 32'(bus.word_ready), 32'd1);
        chk({tag, ".nib_valid"},  32'(bus.nib_valid),  32'd0);
        chk({tag, ".nib_data"},   32'(bus.nib_data),   32'd0);
        chk({tag, ".nib_idx"},    32'(bus.nib_idx),    32'd0);
        chk({tag, ".nib_last"},   32'(bus.nib_last),   32'd0);
        chk({tag, ".busy"},       32'(bus.busy),       32'd0);
    endtask

    // Offer one word, wait (bounded) for acceptance; returns one cycle later
    task automatic send_word(input logic [31:0] w, input logic msb);
        int t;
        bus.word_valid = 1'b1;
        bus.word_data  = w;
        bus.msb_first  = msb;
        t = 0;
        while (!bus.word_ready && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) chk("send_timeout", 32'd1, 32'd0);
        tick();
        bus.word_valid = 1'b0;
    endtask

    // Check eight nibbles. Optional stall of stall_n cycles at position
    // stall_at, optional msb_first/word_data disturbance at flip_at.
    task automatic drain(input string tag, input logic [31:0] seq, input logic msb,
                         input int stall_at, input int stall_n, input int flip_at);
        logic [3:0] en;
        logic [2:0] ei;
        for (int k = 0; k < 8; k++) begin
            en = seq[k*4 +: 4];
            ei = msb ? 3'(7 - k) : 3'(k);
            chk($sformatf("%s.valid%0d", tag, k), 32'(bus.nib_valid), 32'd1);
            chk($sformatf("%s.data%0d",  tag, k), 32'(bus.nib_data),  32'(en));
            chk($sformatf("%s.idx%0d",   tag, k), 32'(bus.nib_idx),   32'(ei));
            chk($sformatf("%s.last%0d",  tag, k), 32'(bus.nib_last),  32'(k == 7));
            if (k == flip_at) begin
                bus.msb_first = ~bus.msb_first;
                bus.word_data = 32'hFFFF_FFFF;
            end
            if (k == stall_at) begin
                bus.nib_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    chk($sformatf("%s.hold_data%0d", tag, s), 32'(bus.nib_data), 32'(en));
                    chk($sformatf("%s.hold_idx%0d",  tag, s), 32'(bus.nib_idx),  32'(ei));
                end
                bus.nib_ready = 1'b1;
            end
            tick();
        end
    endtask

    initial begin
        int cycles;
        int got;
        int t;
        int exp_cycles;
        n_cmp = 0;
        n_err = 0;
        rst            = 1'b1;
        bus.word_valid = 1'b0;
        bus.word_data  = 32'd0;
        bus.msb_first  = 1'b0;
        bus.nib_ready  = 1'b1;

        // Reset values while rst is held
        tick();
        tick();
        chk_reset_vals("rst");
        rst = 1'b0;

        // LSB-first 0x87654321 -> 1..8, then idle
        send_word(32'h8765_4321, 1'b0);
        drain("lsb", 32'h8765_4321, 1'b0, -1, 0, -1);
        chk("lsb.idle_valid", 32'(bus.nib_valid), 32'd0);
        chk("lsb.idle_busy",  32'(bus.busy),      32'd0);

        // MSB-first 0x06000000 -> 0,6,0,0,0,0,0,0
        send_word(32'h0600_0000, 1'b1);
        drain("msb", 32'h0000_0060, 1'b1, -1, 0, -1);
        chk("msb.idle_valid", 32'(bus.nib_valid), 32'd0);

        // Backpressure: 3-cycle stall at idx 2 of 0xDEADBEEF
        send_word(32'hDEAD_BEEF, 1'b0);
        drain("bp", 32'hDEAD_BEEF, 1'b0, 2, 3, -1);
        chk("bp.idle_valid", 32'(bus.nib_valid), 32'd0);

        // Back-to-back words, nib_ready held high
`ifdef NIBBLE_SER_PRELOAD_EN
        exp_cycles = 16;
`else
        exp_cycles = 17;
`endif
        cycles = 0;
        got    = 0;
        fork
            begin
                send_word(32'h1111_1111, 1'b0);
                send_word(32'h2222_2222, 1'b0);
            end
            begin
                t = 0;
                while (!bus.nib_valid && t < 20) begin
                    tick();
                    t++;
                end
                while (got < 16 && cycles < 40) begin
                    cycles++;
                    if (bus.nib_valid) begin
                        chk($sformatf("b2b.data%0d", got), 32'(bus.nib_data),
                            (got < 8) ? 32'd1 : 32'd2);
                        got++;
                    end
                    tick();
                end
            end
        join
        chk("b2b.nibbles", 32'(got),    32'd16);
        chk("b2b.cycles",  32'(cycles), 32'(exp_cycles));
        chk("b2b.idle_valid", 32'(bus.nib_valid), 32'd0);

        // Reset mid-word at idx 4 of 0xFFFFFFFF; a second word is offered
        // during the shift (ignored or held, depending on build) and must
        // also be discarded by reset.
        send_word(32'hFFFF_FFFF, 1'b0);
`ifndef NIBBLE_SER_PRELOAD_EN
        chk("rmw.ready_in_shift", 32'(bus.word_ready), 32'd0);
`endif
        bus.word_valid = 1'b1;
        bus.word_data  = 32'h5555_5555;
        tick();
        bus.word_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("rmw.idx_before", 32'(bus.nib_idx),  32'd4);
        chk("rmw.data_before", 32'(bus.nib_data), 32'hF);
        rst = 1'b1;
        #1;
        chk_reset_vals("rmw");
        tick();
        rst = 1'b0;
        send_word(32'h0000_000A, 1'b0);
        drain("rmw", 32'h0000_000A, 1'b0, -1, 0, -1);
        tick();
        tick();
        chk("rmw.no_stale_valid", 32'(bus.nib_valid), 32'd0);

        // msb_first and word_data disturbed at idx 3 of an LSB-first word
        send_word(32'h8765_4321, 1'b0);
        drain("flip", 32'h8765_4321, 1'b0, -1, 0, 3);
        send_word(32'h8765_4321, 1'b1);
        drain("flip2", 32'h1234_5678, 1'b1, -1, 0, -1);
        chk("flip.idle_valid", 32'(bus.nib_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
